// File: rtl/cp0_unit.sv
// cp0_unit -- Coprocessor-0 register file and exception/interrupt arbiter.
//
// Lives in the M stage. Holds SR, Cause, EPC and PRId, services mfc0/mtc0,
// clears EXL on eret, and raises one combinational request that flushes the
// pipeline and redirects the PC to the exception handler.
//
// Ports:
//   clk        in   1   system clock, all updates on the rising edge
//   reset      in   1   synchronous, active-high; clears SR, Cause, EPC
//   a1         in   5   mfc0 read register number
//   a2         in   5   mtc0 write register number
//   din        in  32   mtc0 write data
//   we         in   1   mtc0 write enable
//   pc_m       in  32   PC of the M-stage instruction
//   bd_m       in   1   M-stage instruction sits in a branch-delay slot
//   exc_code_m in   5   M-stage exception code, 0 = none
//   hw_int     in   6   hardware interrupt lines
//   exl_clr    in   1   eret in the M stage
//   dout       out 32   combinational read data for a1
//   epc_out    out 32   registered EPC
//   req        out  1   combinational exception/interrupt request
//
// There is no handshake: req is a single-cycle level that the pipeline acts
// on in the same cycle; the state change it causes lands on the next edge.
module cp0_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h2024_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  a1,
  input  logic [4:0]  a2,
  input  logic [31:0] din,
  input  logic        we,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_code_m,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic [31:0] dout,
  output logic [31:0] epc_out,
  output logic        req
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR fields
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  // Cause fields
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  // EPC
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic        sr_write;
  logic        epc_write;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  assign sr_word    = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause_word = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b0};

  // Requests use the live hw_int, not the registered IP copy.
  assign int_req = (|(hw_int & im_q)) & ie_q & ~exl_q;
  assign exc_req = (exc_code_m != 5'd0) & ~exl_q;
  assign req     = int_req | exc_req;

  // A taken request suppresses any mtc0 in the same cycle.
  assign sr_write  = we & ~req & (a2 == REG_SR);
  assign epc_write = we & ~req & (a2 == REG_EPC);

  assign epc_out = epc_q;

  // mfc0 read port: same-cycle mtc0 is not forwarded.
  always_comb begin
    dout = 32'd0;
    case (a1)
      REG_SR:    dout = sr_word;
      REG_CAUSE: dout = cause_word;
      REG_EPC:   dout = epc_q;
      REG_PRID:  dout = PRID_VALUE;
      default:   dout = 32'd0;
    endcase
  end

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = hw_int;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;

    if (req) begin
      exl_d      = 1'b1;
      bd_d       = bd_m;
      exc_code_d = int_req ? 5'd0 : exc_code_m;
      // Delay-slot faults restart at the branch; wrap-around is intended.
      epc_d      = bd_m ? (pc_m - 32'd4) : pc_m;
    end else begin
      if (sr_write) begin
        im_d  = din[15:10];
        exl_d = din[1];
        ie_d  = din[0];
      end
      if (epc_write) begin
        epc_d = din;
      end
      // eret wins over an mtc0 that tries to set EXL in the same cycle.
      if (exl_clr) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit -- self-checking bench for cp0_unit.
// Directed scenario tasks plus a randomized run against a word-level model
// of SR/Cause/EPC kept in this file.
module tb_cp0_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [31:0] din;
  logic        we;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exc_code_m;
  logic [5:0]  hw_int;
  logic        exl_clr;
  logic [31:0] dout;
  logic [31:0] epc_out;
  logic        req;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, kept as full architectural register words.
  logic [31:0] m_sr;
  logic [31:0] m_cause;
  logic [31:0] m_epc;

  localparam logic [31:0] PRID = 32'h2024_0007;
  localparam logic [31:0] SR_WMASK = 32'h0000_FC03;

  cp0_unit #(.PRID_VALUE(PRID)) dut (
    .clk(clk), .reset(reset), .a1(a1), .a2(a2), .din(din), .we(we),
    .pc_m(pc_m), .bd_m(bd_m), .exc_code_m(exc_code_m), .hw_int(hw_int),
    .exl_clr(exl_clr), .dout(dout), .epc_out(epc_out), .req(req)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic logic model_int(input logic [31:0] sr, input logic [5:0] hw);
    return ((hw & sr[15:10]) != 6'd0) && sr[0] && !sr[1];
  endfunction

  function automatic logic model_req(input logic [31:0] sr, input logic [5:0] hw,
                                     input logic [4:0] exc);
    return model_int(sr, hw) || ((exc != 5'd0) && !sr[1]);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    reset = 1'b0; we = 1'b0; a1 = 5'd0; a2 = 5'd0; din = 32'd0;
    pc_m = 32'd0; bd_m = 1'b0; exc_code_m = 5'd0; hw_int = 6'd0; exl_clr = 1'b0;
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    logic r, ir;
    r  = model_req(m_sr, hw_int, exc_code_m);
    ir = model_int(m_sr, hw_int);
    @(posedge clk);
    if (reset) begin
      m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
    end else begin
      m_cause[15:10] = hw_int;
      if (r) begin
        m_sr[1]       = 1'b1;
        m_cause[31]   = bd_m;
        m_cause[6:2]  = ir ? 5'd0 : exc_code_m;
        m_epc         = bd_m ? pc_m - 32'd4 : pc_m;
      end else begin
        if (we && a2 == 5'd12) m_sr = din & SR_WMASK;
        if (we && a2 == 5'd14) m_epc = din;
        if (exl_clr) m_sr[1] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic read_reg(input logic [4:0] a, output logic [31:0] v);
    a1 = a;
    #1;
    v = dout;
  endtask

  task automatic leave_exl();
    drive_idle();
    exl_clr = 1'b1;
    tick();
    drive_idle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] v;
    drive_idle();
    reset = 1'b1; we = 1'b1; a2 = 5'd12; din = 32'hFFFF_FFFF; exl_clr = 1'b1;
    tick();
    drive_idle();
    for (int r = 12; r <= 15; r++) begin
      read_reg(5'(r), v);
      n_checks++;
      if (v !== ((r == 15) ? PRID : 32'd0))
        $display("FAIL reset_read reg%0d: got %h want %h", r, v, (r == 15) ? PRID : 32'd0);
      else n_pass++;
    end
    n_checks++;
    if (req !== 1'b0) $display("FAIL reset_req: got %b want 0", req); else n_pass++;
    n_checks++;
    if (epc_out !== 32'd0) $display("FAIL reset_epc: got %h want 0", epc_out); else n_pass++;
    read_reg(5'd7, v);
    n_checks++;
    if (v !== 32'd0) $display("FAIL unmapped_read: got %h want 0", v); else n_pass++;
  endtask

  task automatic test_timer_interrupt();
    logic [31:0] v;
    drive_idle();
    we = 1'b1; a2 = 5'd12; din = 32'h0000_0401;
    tick();
    drive_idle();
    hw_int = 6'b000001; pc_m = 32'h0000_3010; bd_m = 1'b0;
    #1;
    n_checks++;
    if (req !== 1'b1) $display("FAIL timer_req: got %b want 1", req); else n_pass++;
    tick();
    hw_int = 6'd0;
    read_reg(5'd13, v);
    n_checks++;
    if (v !== 32'h0000_0400) $display("FAIL timer_cause: got %h want 00000400", v); else n_pass++;
    n_checks++;
    if (epc_out !== 32'h0000_3010) $display("FAIL timer_epc: got %h want 00003010", epc_out); else n_pass++;
    read_reg(5'd12, v);
    n_checks++;
    if (v !== 32'h0000_0403) $display("FAIL timer_sr: got %h want 00000403", v); else n_pass++;
    n_checks++;
    if (req !== 1'b0) $display("FAIL timer_req_fall: got %b want 0", req); else n_pass++;
    leave_exl();
  endtask

  task automatic test_delay_slot();
    logic [31:0] v;
    drive_idle();
    exc_code_m = 5'd10; bd_m = 1'b1; pc_m = 32'h0000_3004;
    tick();
    drive_idle();
    n_checks++;
    if (epc_out !== 32'h0000_3000) $display("FAIL ds_epc: got %h want 00003000", epc_out); else n_pass++;
    read_reg(5'd13, v);
    n_checks++;
    if (v !== 32'h8000_0028) $display("FAIL ds_cause: got %h want 80000028", v); else n_pass++;
    leave_exl();
  endtask

  task automatic test_priority();
    logic [31:0] v;
    drive_idle();
    we = 1'b1; a2 = 5'd12; din = 32'h0000_1001;
    tick();
    drive_idle();
    hw_int = 6'b000100; exc_code_m = 5'd4; pc_m = 32'h0000_5000;
    we = 1'b1; a2 = 5'd14; din = 32'hDEAD_BEEF;
    tick();
    drive_idle();
    read_reg(5'd13, v);
    n_checks++;
    if (v !== 32'h0000_1000) $display("FAIL prio_cause: got %h want 00001000", v); else n_pass++;
    n_checks++;
    if (epc_out !== 32'h0000_5000) $display("FAIL prio_epc_drop: got %h want 00005000", epc_out); else n_pass++;
    leave_exl();
  endtask

  task automatic test_masking_eret();
    logic [31:0] v;
    drive_idle();
    we = 1'b1; a2 = 5'd12; din = 32'h0000_1003;   // IM2, EXL, IE
    tick();
    drive_idle();
    hw_int = 6'b000100; exc_code_m = 5'd12; pc_m = 32'h0000_7000;
    #1;
    n_checks++;
    if (req !== 1'b0) $display("FAIL mask_req: got %b want 0", req); else n_pass++;
    tick();
    exc_code_m = 5'd0;
    n_checks++;
    if (epc_out !== 32'h0000_5000) $display("FAIL mask_epc: got %h want 00005000", epc_out); else n_pass++;
    read_reg(5'd13, v);
    n_checks++;
    if (v !== 32'h0000_1000) $display("FAIL mask_cause: got %h want 00001000", v); else n_pass++;
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    read_reg(5'd12, v);
    n_checks++;
    if (v !== 32'h0000_1001) $display("FAIL eret_sr: got %h want 00001001", v); else n_pass++;
    n_checks++;
    if (req !== 1'b1) $display("FAIL eret_pending_req: got %b want 1", req); else n_pass++;
    tick();
    n_checks++;
    if (epc_out !== 32'h0000_7000) $display("FAIL eret_int_epc: got %h want 00007000", epc_out); else n_pass++;
    leave_exl();
  endtask

  task automatic test_wraparound();
    drive_idle();
    exc_code_m = 5'd8; bd_m = 1'b1; pc_m = 32'h0000_0000;
    tick();
    drive_idle();
    n_checks++;
    if (epc_out !== 32'hFFFF_FFFC) $display("FAIL wrap_epc: got %h want fffffffc", epc_out); else n_pass++;
    leave_exl();
  endtask

  task automatic test_eret_vs_mtc0();
    logic [31:0] v;
    drive_idle();
    we = 1'b1; a2 = 5'd12; din = 32'h0000_FC03; exl_clr = 1'b1;
    tick();
    drive_idle();
    read_reg(5'd12, v);
    n_checks++;
    if (v !== 32'h0000_FC01) $display("FAIL eret_mtc0_sr: got %h want 0000fc01", v); else n_pass++;
  endtask

  task automatic test_random();
    logic [4:0] regs [5];
    regs = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
    for (int i = 0; i < 400; i++) begin
      drive_idle();
      reset      = ($urandom_range(0, 59) == 0);
      we         = ($urandom_range(0, 2) == 0);
      a2         = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : regs[$urandom_range(0, 3)];
      din        = $urandom;
      a1         = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : regs[$urandom_range(0, 4)];
      pc_m       = $urandom & 32'hFFFF_FFFC;
      bd_m       = 1'($urandom_range(0, 1));
      exc_code_m = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      hw_int     = {3'b000, 3'($urandom_range(0, 7))};
      exl_clr    = ($urandom_range(0, 3) == 0);
      #1;
      n_checks++;
      if (req !== model_req(m_sr, hw_int, exc_code_m))
        $display("FAIL rand_req cyc%0d: got %b want %b", i, req, model_req(m_sr, hw_int, exc_code_m));
      else n_pass++;
      n_checks++;
      if (dout !== model_read(a1))
        $display("FAIL rand_dout cyc%0d reg%0d: got %h want %h", i, a1, dout, model_read(a1));
      else n_pass++;
      n_checks++;
      if (epc_out !== m_epc)
        $display("FAIL rand_epc cyc%0d: got %h want %h", i, epc_out, m_epc);
      else n_pass++;
      tick();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    drive_idle();
    reset = 1'b1;
    m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
    @(negedge clk);
    test_reset();
    test_timer_interrupt();
    test_delay_slot();
    test_priority();
    test_masking_eret();
    test_wraparound();
    test_eret_vs_mtc0();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
